// File: rtl/param_alu.sv
// Combinational ALU: ADD/SUB/AND/OR/XOR/SHL/SHR with {Z,N,C,V} flags.
// Opcode 111 is unsupported and yields zero.
module param_alu #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [2:0]   op_i,
  output logic [W-1:0] y_o,
  output logic [3:0]   flags_o
);

  localparam int unsigned ShW = $clog2(W);

  logic [W:0]   sum;
  logic [W-1:0] y;
  logic         c;
  logic         v;

  // Operation decode; C and V are only meaningful for ADD/SUB and stay 0 otherwise
  always_comb begin
    sum = '0;
    y   = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (op_i)
      3'b000: begin
        sum = {1'b0, a_i} + {1'b0, b_i};
        y   = sum[W-1:0];
        c   = sum[W];
        v   = (a_i[W-1] == b_i[W-1]) && (y[W-1] != a_i[W-1]);
      end
      3'b001: begin
        sum = {1'b0, a_i} - {1'b0, b_i};
        y   = sum[W-1:0];
        c   = ~sum[W];  // no-borrow
        v   = (a_i[W-1] != b_i[W-1]) && (y[W-1] != a_i[W-1]);
      end
      3'b010:  y = a_i & b_i;
      3'b011:  y = a_i | b_i;
      3'b100:  y = a_i ^ b_i;
      3'b101:  y = a_i << b_i[ShW-1:0];
      3'b110:  y = a_i >> b_i[ShW-1:0];
      default: y = '0;
    endcase
  end

  assign y_o     = y;
  assign flags_o = {(y == '0), y[W-1], c, v};

endmodule

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one param_alu between NREQ requesters,
// with a one-entry tagged response register and an accept counter.
module alu_rr_sched #(
  parameter int unsigned W    = 8,
  parameter int unsigned NREQ = 4,
  localparam int unsigned IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*3-1:0] req_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_y,
  output logic [3:0]        rsp_flags,
  output logic              rsp_err,
  output logic [15:0]       accept_cnt
);

  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [W-1:0]    rsp_y_q, rsp_y_d;
  logic [3:0]      rsp_flags_q, rsp_flags_d;
  logic            rsp_err_q, rsp_err_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [15:0]     cnt_q, cnt_d;

  logic            free;
  logic            accept;
  logic            found;
  logic [IDW-1:0]  cand;
  logic [IDW-1:0]  gidx;
  logic [NREQ-1:0] grant;
  logic [W-1:0]    sel_a, sel_b, alu_y;
  logic [2:0]      sel_op;
  logic [3:0]      alu_flags;

  // Search ptr+1 .. ptr (mod NREQ); first valid requester wins
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      cand = IDW'((int'(ptr_q) + k) % int'(NREQ));
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        gidx  = cand;
      end
    end
    grant[gidx] = found;
  end

  assign free      = ~rsp_valid_q | rsp_ready;
  // Gate with rst_n so no handshake can complete while reset is held
  assign req_ready = (rst_n && free) ? grant : '0;
  assign accept    = |req_ready;

  // Steer the winner's operands to the shared ALU
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant[i]) begin
        sel_a  = req_a[i*W +: W];
        sel_b  = req_b[i*W +: W];
        sel_op = req_op[i*3 +: 3];
      end
    end
  end

  param_alu #(
    .W (W)
  ) u_alu (
    .a_i     (sel_a),
    .b_i     (sel_b),
    .op_i    (sel_op),
    .y_o     (alu_y),
    .flags_o (alu_flags)
  );

  // Response register load/drain, priority pointer and counter next state
  always_comb begin
    rsp_valid_d = rsp_valid_q & ~rsp_ready;
    rsp_id_d    = rsp_id_q;
    rsp_y_d     = rsp_y_q;
    rsp_flags_d = rsp_flags_q;
    rsp_err_d   = rsp_err_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = gidx;
      rsp_y_d     = alu_y;
      rsp_flags_d = alu_flags;
      rsp_err_d   = (sel_op == 3'b111);
      ptr_d       = gidx;
      cnt_d       = cnt_q + 16'd1;
    end
  end

  // State registers; ptr resets to NREQ-1 so requester 0 is searched first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_y_q     <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= 1'b0;
      ptr_q       <= IDW'(NREQ - 1);
      cnt_q       <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_y_q     <= rsp_y_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_err_q   <= rsp_err_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_y      = rsp_y_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_err    = rsp_err_q;
  assign accept_cnt = cnt_q;

endmodule

// File: doc/alu_rr_sched.md
# alu_rr_sched

Round-robin scheduler that shares one `param_alu` instance between `NREQ` independent requesters. Each requester presents an operation (a, b, op) on a valid/ready port. The scheduler grants one requester per cycle, drives the shared ALU and captures the result and flags in a one-entry response register tagged with the requester ID. It sits between the issue logic of several client blocks and the single combinational ALU datapath.

## Interface
One clock; reset is asynchronous and active-low.

Parameters:
- `W`, default 8: operand/result width, passed to `param_alu`; must be ≥ 2.
- `NREQ`, default 4: number of requesters, ≥ 2; `IDW` = `$clog2(NREQ)`.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  NREQ  per-requester command valid.
- `req_ready`  out  NREQ  per-requester accept; at most one bit high per cycle.
- `req_a`  in  NREQ*W  operand A; requester i at `[i*W +: W]`.
- `req_b`  in  NREQ*W  operand B; same packing.
- `req_op`  in  NREQ*3  opcode; requester i at `[i*3 +: 3]`; encoding as `param_alu` (000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR).
- `rsp_valid`  out  1  response register holds a result.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  IDW  index of the requester that produced the response.
- `rsp_y`  out  W  ALU result.
- `rsp_flags`  out  4  {Z,N,C,V} from the ALU.
- `rsp_err`  out  1  opcode was 111 (unsupported).
- `accept_cnt`  out  16  count of accepted commands; wraps.

## Operation
- **Response register state:** EMPTY (`rsp_valid`=0) or FULL (`rsp_valid`=1).
- **Free condition:** `free` = ~`rsp_valid` | `rsp_ready`.
- **Arbitration:**
  - `ptr` (IDW bits) holds the last granted index.
  - Search order is `ptr`+1, `ptr`+2, …, `ptr` (modulo NREQ). The first requester with `req_valid`=1 wins.
  - `grant` is combinational from `req_valid` and `ptr`.
- **Accept:** `req_ready[i]` = `grant[i]` & `free`. An accept happens when `req_valid[i]` & `req_ready[i]`.
- **Mux to ALU:** the winner's a/b/op drive the single `param_alu` instance combinationally.
- **On accept (clock edge):**
  - Capture `rsp_y`, `rsp_flags`, `rsp_id` = i, and `rsp_err` = (op==111).
  - Set `rsp_valid`=1 and `ptr`=i.
  - Increment `accept_cnt` (0xFFFF → 0x0000).
- **No accept, `rsp_ready`=1 while FULL:** `rsp_valid`→0; data fields hold their last values.
- **Drain and accept in the same cycle:** the register is reloaded and `rsp_valid` stays 1. Sustained throughput is 1 op/cycle.
- **`ptr` update:** `ptr` changes only on accept. Idle cycles do not move priority.
- **Opcode 111:** the ALU yields y=0, so `rsp_y`=0, `rsp_flags`=1000 (Z=1) and `rsp_err`=1. The command is accepted and responded to normally.
- **Requester rules:** once `req_valid` is high, a/b/op stay stable until accepted. `req_valid` must not depend on `req_ready`.
- **Consumer rules:** while FULL and `rsp_ready`=0, all `rsp_*` outputs hold stable.
- **Width rules:**
  - ADD/SUB carry, overflow, Z and N are exactly the `param_alu` flags.
  - SUB C = no-borrow.
  - Shift amount is `b[$clog2(W)-1:0]`.

## Timing
- **Reset values (async assert, sync-safe deassert):**
  - `rsp_valid`=0, `rsp_y`=0, `rsp_flags`=0, `rsp_id`=0, `rsp_err`=0, `accept_cnt`=0.
  - `ptr`=NREQ-1, so requester 0 has first priority.
- **Reset outputs:** `req_ready` is all-zero while `rst_n`=0.
- **Latency:** a command accepted at edge k appears on `rsp_*` with `rsp_valid`=1 immediately after edge k (1 cycle).
- **Combinational paths:**
  - `req_valid` → `req_ready`.
  - `rsp_ready` → `req_ready`.
  - No path from `rsp_ready` to `rsp_*`.
- **Reset mid-operation:** a FULL response is discarded. The command the reset interrupts is not accepted. After release, arbitration restarts at requester 0.

## Test plan
- **Single requester ADD:** W=8, NREQ=4, `rsp_ready`=1. Req0 a=7F, b=01, op=000 for one cycle. Required: `req_ready[0]`=1 that cycle; next cycle `rsp_valid`=1, `rsp_id`=0, `rsp_y`=80, `rsp_flags`=0101, `accept_cnt`=1.
- **Round-robin fairness:** all four `req_valid` held high, `rsp_ready`=1. Required: grants go 0,1,2,3,0,1 on consecutive cycles, exactly one `req_ready` high per cycle, `rsp_id` follows one cycle later. Drop req1 → order becomes 0,2,3,0.
- **Backpressure:** response FULL (req2 SUB a=00 b=01 → `rsp_y`=FF, flags 0100), `rsp_ready`=0 for 3 cycles with req0/req3 valid. Required: all `req_ready`=0 and `rsp_*` stable. When `rsp_ready`=1: drain and accept req3 in the same cycle, `rsp_valid` stays 1.
- **Unsupported op:** req1 op=111, a=55, b=AA. Required: `rsp_y`=00, `rsp_flags`=1000, `rsp_err`=1, `rsp_id`=1. The next valid op clears `rsp_err`.
- **Reset mid-stream:** `rst_n`=0 while `rsp_valid`=1 and `ptr`=2, all requesters valid. Required: immediately `rsp_valid`=0 and `accept_cnt`=0. After release, the first grant goes to req0.
- **Counter wrap:** force 65536 accepts (or preload via reset plus 65535 ops, then one more). Required: `accept_cnt` goes 0xFFFF → 0x0000 with no effect on responses.
